// File: rtl/pipelined_array_multiplier.sv
// NxN array multiplier (unsigned or Baugh-Wooley signed) with mask-selected pipeline stages
// and valid/ready flow control. Define ARRAY_MULT_PERF_CNT_EN to add the performance counters.
module pipelined_array_multiplier #(
    parameter int                 DATAWIDTH           = 8,
    parameter logic [DATAWIDTH:0] PIPELINE_STAGE_MASK = '1,
    parameter int                 TAG_WIDTH           = 4,
    parameter int                 INSTANCE_ID         = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready_in,
    input  logic [DATAWIDTH-1:0]   A,
    input  logic [DATAWIDTH-1:0]   B,
    input  logic                   i_signed,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_valid,
    input  logic                   i_ready_out,
    output logic [2*DATAWIDTH-1:0] Z_final,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic                   o_signed
`ifdef ARRAY_MULT_PERF_CNT_EN
    ,
    output logic [31:0]            o_accept_cnt,
    output logic [31:0]            o_result_cnt,
    output logic [31:0]            o_stall_cnt
`endif
);

    // INSTANCE_ID is informational only and folds away here.
    localparam int N = DATAWIDTH + 0 * INSTANCE_ID;
    localparam int L = $countones(PIPELINE_STAGE_MASK);

    // One in-flight slot: operands, partial products, carry-save row state and frozen product bits.
    typedef struct packed {
        logic [N-1:0]         a;
        logic [N-1:0]         b;
        logic [N*N-1:0]       pp;
        logic [N-1:0]         s;
        logic [N-1:0]         c;
        logic [2*N-1:0]       z;
        logic [TAG_WIDTH-1:0] tag;
        logic                 sgn;
    } slot_t;

    function automatic slot_t gen_pp(slot_t x);
        slot_t y;
        y = x;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                y.pp[i*N+j] = (x.a[i] & x.b[j]) ^ (x.sgn & ((i == N - 1) != (j == N - 1)));
            end
        end
        for (int i = 0; i < N; i++) begin
            y.s[i] = y.pp[i*N];
        end
        y.c = '0;
        return y;
    endfunction

    // Adds partial-product row j into the carry-save pair and freezes product bit j-1.
    function automatic slot_t row_step(slot_t x, int j);
        slot_t y;
        logic  t;
        y = x;
        y.z[j-1] = x.s[0] ^ x.c[0];
        y.c[0]   = x.s[0] & x.c[0];
        for (int p = 1; p < N; p++) begin
            t          = x.pp[(p-1)*N+j];
            y.s[p-1]   = x.s[p] ^ x.c[p] ^ t;
            y.c[p]     = (x.s[p] & x.c[p]) | (t & (x.s[p] ^ x.c[p]));
        end
        y.s[N-1] = x.pp[(N-1)*N+j];
        return y;
    endfunction

    // Carry-propagate row; Baugh-Wooley constants 2^N and 2^(2N-1) sit at bits 1 and N of this word.
    function automatic slot_t cpa(slot_t x);
        slot_t      y;
        logic [N:0] k;
        y    = x;
        k    = '0;
        k[1] = x.sgn;
        k[N] = x.sgn;
        y.z[2*N-1:N-1] = {1'b0, x.s} + {1'b0, x.c} + k;
        return y;
    endfunction

    function automatic slot_t stage_fn(int k, slot_t x);
        slot_t y;
        if (k == 0)      y = x;
        else if (k == 1) y = gen_pp(x);
        else if (k == N) y = cpa(row_step(x, N - 1));
        else             y = row_step(x, k - 1);
        return y;
    endfunction

    slot_t      data_p [0:N];
    logic [N:0] vld_p;
    slot_t      nxt    [0:N];
    logic [N:0] nxt_vld;
    slot_t      cur;
    logic       cur_vld;
    logic       en;

    always_comb begin
        cur         = '0;
        cur.a       = A & {N{i_valid}};
        cur.b       = B & {N{i_valid}};
        cur.tag     = i_tag & {TAG_WIDTH{i_valid}};
        cur.sgn     = i_signed & i_valid;
        cur_vld     = i_valid;
        nxt_vld     = '0;
        for (int k = 0; k <= N; k++) begin
            nxt[k]     = stage_fn(k, cur);
            nxt_vld[k] = cur_vld;
            cur        = PIPELINE_STAGE_MASK[k] ? data_p[k] : nxt[k];
            cur_vld    = PIPELINE_STAGE_MASK[k] ? vld_p[k] : cur_vld;
        end
    end

    assign o_valid    = cur_vld;
    assign Z_final    = cur.z;
    assign o_tag      = cur.tag;
    assign o_signed   = cur.sgn;
    assign en         = i_ready_out | ~o_valid;
    assign o_ready_in = (L == 0) ? i_ready_out : en;

    // Stage boundaries: every masked-in stage loads together under the global enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= N; k++) begin
                data_p[k] <= '0;
                vld_p[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k <= N; k++) begin
                if (PIPELINE_STAGE_MASK[k]) begin
                    data_p[k] <= nxt[k];
                    vld_p[k]  <= nxt_vld[k];
                end
            end
        end
    end

`ifdef ARRAY_MULT_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(logic [31:0] cnt, logic inc);
        return (inc && (cnt != 32'hFFFF_FFFF)) ? cnt + 32'd1 : cnt;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_accept_cnt <= '0;
            o_result_cnt <= '0;
            o_stall_cnt  <= '0;
        end else begin
            o_accept_cnt <= sat_inc(o_accept_cnt, i_valid & o_ready_in);
            o_result_cnt <= sat_inc(o_result_cnt, o_valid & i_ready_out);
            o_stall_cnt  <= sat_inc(o_stall_cnt, o_valid & ~i_ready_out);
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Bench for pipelined_array_multiplier: table vectors, random streams with backpressure,
// reset, mask variants and (with ARRAY_MULT_PERF_CNT_EN) the performance counters.
module tb_pipelined_array_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference products from plain integer arithmetic.
    function automatic logic [15:0] ref8(logic [7:0] a, logic [7:0] b, logic s);
        logic signed [15:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (s) return sa * sb;
        return {8'd0, a} * {8'd0, b};
    endfunction

    function automatic logic [31:0] ref16(logic [15:0] a, logic [15:0] b, logic s);
        logic signed [31:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (s) return sa * sb;
        return {16'd0, a} * {16'd0, b};
    endfunction

    // Main DUT, default parameters.
    logic        rst, i_valid, i_signed, i_ready_out, o_ready_in, o_valid, o_signed;
    logic [7:0]  A, B;
    logic [3:0]  i_tag, o_tag;
    logic [15:0] Z_final;
`ifdef ARRAY_MULT_PERF_CNT_EN
    logic [31:0] acc_cnt, res_cnt, stl_cnt, x0, x1, x2, y0, y1, y2, w0, w1, w2;
`endif

    pipelined_array_multiplier u_dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready_in(o_ready_in), .A(A), .B(B),
        .i_signed(i_signed), .i_tag(i_tag), .o_valid(o_valid), .i_ready_out(i_ready_out),
        .Z_final(Z_final), .o_tag(o_tag), .o_signed(o_signed)
`ifdef ARRAY_MULT_PERF_CNT_EN
        , .o_accept_cnt(acc_cnt), .o_result_cnt(res_cnt), .o_stall_cnt(stl_cnt)
`endif
    );

    // Mask variants: fully combinational and two-stage, fed from a shared stimulus.
    logic        x_valid, x_signed, x_rdy, c_rdy_in, c_valid, c_signed, l_rdy_in, l_valid, l_signed;
    logic [7:0]  xa, xb;
    logic [3:0]  x_tag, c_tag, l_tag;
    logic [15:0] c_z, l_z;

    pipelined_array_multiplier #(.PIPELINE_STAGE_MASK(9'b0)) u_comb (
        .clk(clk), .rst(rst), .i_valid(x_valid), .o_ready_in(c_rdy_in), .A(xa), .B(xb),
        .i_signed(x_signed), .i_tag(x_tag), .o_valid(c_valid), .i_ready_out(x_rdy),
        .Z_final(c_z), .o_tag(c_tag), .o_signed(c_signed)
`ifdef ARRAY_MULT_PERF_CNT_EN
        , .o_accept_cnt(x0), .o_result_cnt(x1), .o_stall_cnt(x2)
`endif
    );

    pipelined_array_multiplier #(.PIPELINE_STAGE_MASK(9'b100000001)) u_l2 (
        .clk(clk), .rst(rst), .i_valid(x_valid), .o_ready_in(l_rdy_in), .A(xa), .B(xb),
        .i_signed(x_signed), .i_tag(x_tag), .o_valid(l_valid), .i_ready_out(x_rdy),
        .Z_final(l_z), .o_tag(l_tag), .o_signed(l_signed)
`ifdef ARRAY_MULT_PERF_CNT_EN
        , .o_accept_cnt(y0), .o_result_cnt(y1), .o_stall_cnt(y2)
`endif
    );

    // 16-bit, all stages enabled.
    logic        w_valid, w_signed, w_rdy_in, w_ovalid, w_osigned;
    logic [15:0] wa, wb;
    logic [3:0]  w_tag, w_otag;
    logic [31:0] w_z;

    pipelined_array_multiplier #(.DATAWIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .i_valid(w_valid), .o_ready_in(w_rdy_in), .A(wa), .B(wb),
        .i_signed(w_signed), .i_tag(w_tag), .o_valid(w_ovalid), .i_ready_out(x_rdy),
        .Z_final(w_z), .o_tag(w_otag), .o_signed(w_osigned)
`ifdef ARRAY_MULT_PERF_CNT_EN
        , .o_accept_cnt(w0), .o_result_cnt(w1), .o_stall_cnt(w2)
`endif
    );

    typedef struct packed {
        logic [15:0] z;
        logic [3:0]  tag;
        logic        sgn;
    } exp_t;

    exp_t q[$];
    int   acc_n, res_n, stall_n;
    logic bp_mode = 1'b0;
    logic rdy_force = 1'b1;

    // Ready driver: 2 cycles high, 3 low in backpressure mode.
    initial begin
        int cyc = 0;
        i_ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            i_ready_out = bp_mode ? ((cyc % 5) < 2) : rdy_force;
            cyc++;
        end
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    initial begin
        exp_t        e;
        logic        held_v;
        logic [20:0] held;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                acc_n = 0; res_n = 0; stall_n = 0; held_v = 1'b0;
            end else begin
                if (held_v) check("hold", 64'({o_valid, o_signed, o_tag, Z_final}), 64'({1'b1, held}));
                held_v = 1'b0;
                if (i_valid && o_ready_in) acc_n++;
                if (o_valid && !i_ready_out) begin
                    stall_n++;
                    check("ready_in_stalled", 64'(o_ready_in), 64'd0);
                    held_v = 1'b1;
                    held   = {o_signed, o_tag, Z_final};
                end
                if (o_valid && i_ready_out) begin
                    res_n++;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got z=%h tag=%h expected none", Z_final, o_tag);
                    end else begin
                        e = q.pop_front();
                        check("result", 64'({o_signed, o_tag, Z_final}), 64'({e.sgn, e.tag, e.z}));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(logic [7:0] a, logic [7:0] b, logic s, logic [3:0] t, logic [15:0] z);
        int   n = 0;
        exp_t e;
        A = a; B = b; i_signed = s; i_tag = t; i_valid = 1'b1;
        @(negedge clk);
        while (!o_ready_in && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        e.z = z; e.tag = t; e.sgn = s;
        q.push_back(e);
        #1;
        i_valid = 1'b0; A = '0; B = '0; i_tag = '0; i_signed = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  a, b;
        logic        s;
        logic [3:0]  t;
        logic [15:0] z;
    } vec_t;

    vec_t        vt[12];
    logic [15:0] hz[16];
    logic [3:0]  ht[16];

    initial begin
        vt[0]  = '{8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01};
        vt[1]  = '{8'h80, 8'h80, 1'b1, 4'h4, 16'h4000};
        vt[2]  = '{8'h81, 8'h02, 1'b0, 4'h5, 16'h0102};
        vt[3]  = '{8'hFF, 8'h05, 1'b1, 4'h6, 16'hFFFB};
        vt[4]  = '{8'h81, 8'h02, 1'b0, 4'h7, 16'h0102};
        vt[5]  = '{8'h7F, 8'h81, 1'b1, 4'h8, 16'hC0FF};  // 127 * -127 = -16129
        vt[6]  = '{8'h00, 8'hFF, 1'b1, 4'h9, 16'h0000};
        vt[7]  = '{8'hFF, 8'hFF, 1'b1, 4'hA, 16'h0001};
        vt[8]  = '{8'h80, 8'h7F, 1'b1, 4'hB, 16'hC080};
        vt[9]  = '{8'h7F, 8'h7F, 1'b0, 4'hC, 16'h3F01};
        vt[10] = '{8'hFF, 8'h80, 1'b1, 4'hD, 16'h0080};
        vt[11] = '{8'hFF, 8'h80, 1'b0, 4'hE, 16'h7F80};

        rst = 1'b0; i_valid = 1'b0; A = '0; B = '0; i_signed = 1'b0; i_tag = '0;
        x_valid = 1'b0; xa = '0; xb = '0; x_signed = 1'b0; x_tag = '0; x_rdy = 1'b1;
        w_valid = 1'b0; wa = '0; wb = '0; w_signed = 1'b0; w_tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'({o_valid, o_signed, o_tag, Z_final}), 64'd0);
        check("reset_ready", 64'(o_ready_in), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Latency of the default build: result appears in the 9th cycle after acceptance.
        @(posedge clk);
        #1;
        send(8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFE01);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("lat9_not_yet", 64'(o_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat9_valid", 64'({o_valid, o_tag, Z_final}), 64'({1'b1, 4'h3, 16'hFE01}));
        drain();

        // Table vectors, back-to-back, mixed modes.
        foreach (vt[i]) send(vt[i].a, vt[i].b, vt[i].s, vt[i].t, vt[i].z);
        drain();

        // Random stream under backpressure, then at full rate.
        bp_mode = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a, b;
            logic       s;
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            send(a, b, s, 4'(i), ref8(a, b, s));
        end
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] a, b;
            logic       s;
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            send(a, b, s, 4'(i), ref8(a, b, s));
        end
        drain();

        // Asynchronous reset with five transactions in flight.
        for (int i = 0; i < 5; i++) send(8'(i + 3), 8'hF0, 1'b0, 4'(i), ref8(8'(i + 3), 8'hF0, 1'b0));
        #2 rst = 1'b0;
        q.delete();
        #1;
        check("midreset_cleared", 64'({o_valid, Z_final}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        send(8'h12, 8'h34, 1'b0, 4'h1, 16'h03A8);
        drain();

        // Mask variants: combinational and two-register builds.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            xa = 8'($urandom); xb = 8'($urandom); x_signed = 1'($urandom); x_tag = 4'(i);
            x_valid = 1'b1;
            hz[i] = ref8(xa, xb, x_signed);
            ht[i] = 4'(i);
            @(negedge clk);
            check("comb_result", 64'({c_valid, c_tag, c_z}), 64'({1'b1, ht[i], hz[i]}));
            if (i < 2) check("l2_empty", 64'(l_valid), 64'd0);
            else check("l2_result", 64'({l_valid, l_tag, l_z}), 64'({1'b1, ht[i-2], hz[i-2]}));
        end
        @(posedge clk);
        #1 x_valid = 1'b0;

        // 16-bit build: latency 17.
        for (int t = 0; t < 3; t++) begin
            logic [31:0] ez;
            case (t)
                0:       begin wa = 16'hFFFF; wb = 16'hFFFF; w_signed = 1'b0; end
                1:       begin wa = 16'h8000; wb = 16'h8000; w_signed = 1'b1; end
                default: begin wa = 16'($urandom); wb = 16'($urandom); w_signed = 1'b1; end
            endcase
            ez = (t == 0) ? 32'hFFFE0001 : (t == 1) ? 32'h40000000 : ref16(wa, wb, w_signed);
            w_tag = 4'(t); w_valid = 1'b1;
            @(posedge clk);
            #1 w_valid = 1'b0;
            repeat (15) @(posedge clk);
            @(negedge clk);
            check("w16_not_yet", 64'(w_ovalid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("w16_result", 64'({w_ovalid, w_otag, w_z}), 64'({1'b1, 4'(t), ez}));
            @(posedge clk);
            #1;
        end

`ifdef ARRAY_MULT_PERF_CNT_EN
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) send(8'(i), 8'(i + 1), 1'b0, 4'(i), ref8(8'(i), 8'(i + 1), 1'b0));
        @(negedge clk);
        rdy_force = 1'b0;
        repeat (5) @(posedge clk);
        rdy_force = 1'b1;
        drain();
        @(negedge clk);
        check("perf_accept", 64'(acc_cnt), 64'd10);
        check("perf_result", 64'(res_cnt), 64'(res_n));
        check("perf_stall", 64'(stl_cnt), 64'(stall_n));
        check("perf_stall4", 64'(stl_cnt), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
